lcd_bus_responder: RTL and testbench

//  Synthesizable HD44780-style LCD receiver: the display end of the LCD_RS/RW/EN/DATA bus driven by the game's
//  LCD controller. Decodes commands and characters, holds 2x40 DDRAM and a busy flag, and answers bus reads.

---
 rtl/lcd_bus_responder.sv | 154 +++++++++++++++
 tb/tb_lcd_bus_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style LCD bus endpoint with 2x40 DDRAM, busy flag, command decode and bus read-back
module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 4,
  parameter int CLEAR_CYCLES = 150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic [7:0] LCD_DATA_IN,
  output logic [7:0] LCD_DATA_OUT,
  output logic       LCD_DATA_OE,
  output logic       busy,
  output logic [1:0] state,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       char_valid,
  output logic [7:0] char_byte,
  output logic [6:0] char_addr,
  output logic       err_busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  input  logic [6:0] dbg_rd_addr,
  output logic [7:0] dbg_rd_data
);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_CLEAR = 2'd2;
  localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);
  function automatic logic f_mapped(input logic [6:0] a);
    return a[5:0] < 6'd40;
  endfunction
  function automatic logic [6:0] f_idx(input logic [6:0] a);
    return a[6] ? {1'b0, a[5:0]} + 7'd40 : {1'b0, a[5:0]};
  endfunction
  function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc);
    return inc ? (a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1)
               : (a == 7'h00 ? 7'h67 : a == 7'h40 ? 7'h27 : a - 7'd1);
  endfunction
  logic [1:0]    r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [6:0]    r_addr, r_sweep, r_chr_a;
  logic [7:0]    r_ram [0:79];
  logic [7:0]    r_data, r_dout, r_cmd_b, r_chr_b, w_cur;
  logic          r_en_q, r_rs, r_rw, r_oe, r_cmd_v, r_chr_v, r_err;
  logic          r_disp, r_cur, r_blink, r_inc;
  logic          w_busy, w_fall, w_wr, w_wr_ok, w_rd_dat;
  always_comb begin
    w_busy   = r_state != S_IDLE;
    w_fall   = r_en_q & ~LCD_EN;
    w_wr     = w_fall & ~r_rw;
    w_wr_ok  = w_wr & ~w_busy;
    w_rd_dat = w_fall & r_rw & r_rs;
    w_cur    = f_mapped(r_addr) ? r_ram[f_idx(r_addr)] : 8'h00;
  end
  always_ff @(posedge clk) begin
    r_state <= !rst ? S_IDLE : w_next;
  end
  always_comb begin
    w_next = r_state == S_IDLE ? (w_wr_ok ? ((!r_rs && r_data == 8'h01) ? S_CLEAR : S_EXEC) : S_IDLE)
                               : (r_cnt == '0 ? S_IDLE : r_state);
  end
  always_comb begin
    busy         = w_busy;
    state        = r_state;
    LCD_DATA_OUT = r_dout;
    LCD_DATA_OE  = r_oe;
    cmd_valid    = r_cmd_v;
    cmd_byte     = r_cmd_b;
    char_valid   = r_chr_v;
    char_byte    = r_chr_b;
    char_addr    = r_chr_a;
    err_busy     = r_err;
    display_on   = r_disp;
    cursor_on    = r_cur;
    blink_on     = r_blink;
    inc_mode     = r_inc;
    dbg_rd_data  = f_mapped(dbg_rd_addr) ? r_ram[f_idx(dbg_rd_addr)] : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en_q  <= 1'b0;
      r_rs    <= 1'b0;
      r_rw    <= 1'b0;
      r_data  <= 8'h00;
      r_oe    <= 1'b0;
      r_dout  <= 8'h00;
      r_cmd_v <= 1'b0;
      r_cmd_b <= 8'h00;
      r_chr_v <= 1'b0;
      r_chr_b <= 8'h00;
      r_chr_a <= 7'h00;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= 7'h00;
      r_sweep <= 7'd80;
      r_inc   <= 1'b1;
      r_disp  <= 1'b0;
      r_cur   <= 1'b0;
      r_blink <= 1'b0;
      for (int i = 0; i < 80; i++) r_ram[i] <= 8'h20;
    end else begin
      r_en_q <= LCD_EN;
      if (LCD_EN) begin
        r_rs   <= LCD_RS;
        r_rw   <= LCD_RW;
        r_data <= LCD_DATA_IN;
      end
      r_oe    <= LCD_EN & LCD_RW;
      r_dout  <= !(LCD_EN && LCD_RW) ? 8'h00 : !LCD_RS ? {w_busy, r_addr} : w_busy ? 8'h00 : w_cur;
      r_cmd_v <= w_wr_ok & ~r_rs;
      r_chr_v <= w_wr_ok & r_rs;
      r_err   <= w_busy & (w_wr | w_rd_dat);
      if (w_busy && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_state == S_CLEAR && r_sweep < 7'd80) begin
        r_ram[r_sweep] <= 8'h20;
        r_sweep        <= r_sweep + 7'd1;
        if (r_sweep == 7'd79) begin
          r_addr <= 7'h00;
          r_inc  <= 1'b1;
        end
      end
      if (w_rd_dat && !w_busy) r_addr <= f_step(r_addr, r_inc);
      if (w_wr_ok) begin
        r_cnt <= BUSY_LOAD;
        if (r_rs) begin
          r_ram[f_idx(r_addr)] <= r_data;
          r_chr_b              <= r_data;
          r_chr_a              <= r_addr;
          r_addr               <= f_step(r_addr, r_inc);
        end else begin
          r_cmd_b <= r_data;
          if (r_data[7]) begin
            r_addr <= f_mapped(r_data[6:0]) ? r_data[6:0] : r_addr;
          end else if (r_data[6:5] == 2'b00) begin
            if (r_data[4]) r_addr <= r_data[3] ? r_addr : f_step(r_addr, r_data[2]);
            else if (r_data[3]) {r_disp, r_cur, r_blink} <= r_data[2:0];
            else if (r_data[2]) r_inc <= r_data[1];
            else if (r_data[1]) begin
              r_addr <= 7'h00;
              r_cnt  <= CLEAR_LOAD;
            end else if (r_data[0]) begin
              r_cnt   <= CLEAR_LOAD;
              r_sweep <= 7'd0;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: directed stimulus with a queue scoreboard checking lcd_bus_responder responses
module tb_lcd_bus_responder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       LCD_RS = 1'b0, LCD_RW = 1'b0, LCD_EN = 1'b0;
  logic [7:0] LCD_DATA_IN = 8'h00;
  logic [7:0] LCD_DATA_OUT;
  logic       LCD_DATA_OE, busy;
  logic [1:0] state;
  logic       cmd_valid, char_valid, err_busy;
  logic [7:0] cmd_byte, char_byte;
  logic [6:0] char_addr;
  logic       display_on, cursor_on, blink_on, inc_mode;
  logic [6:0] dbg_rd_addr = 7'h00;
  logic [7:0] dbg_rd_data;
  typedef struct packed {
    logic [1:0]  k;
    logic [15:0] v;
  } item_t;
  item_t q[$];
  int    errors = 0;
  int    checks = 0;
  logic  prev_oe = 1'b0;
  lcd_bus_responder dut (
    .clk(clk), .rst(rst), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_DATA_IN(LCD_DATA_IN), .LCD_DATA_OUT(LCD_DATA_OUT), .LCD_DATA_OE(LCD_DATA_OE),
    .busy(busy), .state(state), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .char_valid(char_valid), .char_byte(char_byte), .char_addr(char_addr),
    .err_busy(err_busy), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .inc_mode(inc_mode), .dbg_rd_addr(dbg_rd_addr),
    .dbg_rd_data(dbg_rd_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic sb(input logic [1:0] k, input logic [15:0] v);
    item_t it;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: unexpected kind=%0d value %0h with empty queue", k, v);
    end else begin
      it = q.pop_front();
      if (it.k !== k || it.v !== v) begin
        errors++;
        $display("FAIL scoreboard: got kind=%0d value %0h expected kind=%0d value %0h", k, v, it.k, it.v);
      end
    end
  endtask
  always @(negedge clk) begin
    if (cmd_valid) sb(2'd0, {8'h00, cmd_byte});
    if (char_valid) sb(2'd1, {1'b0, char_addr, char_byte});
    if (err_busy) sb(2'd2, 16'h0000);
    if (LCD_DATA_OE && !prev_oe) sb(2'd3, {8'h00, LCD_DATA_OUT});
    prev_oe <= LCD_DATA_OE;
  end
  task automatic push(input logic [1:0] k, input logic [15:0] v);
    q.push_back('{k: k, v: v});
  endtask
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int hold);
    @(posedge clk); #1;
    LCD_RS = rs; LCD_RW = rw; LCD_DATA_IN = d; LCD_EN = 1'b1;
    @(posedge clk); #1;
    if (rw) chk("oe_on", {15'h0, LCD_DATA_OE}, 16'h1);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
    end
    LCD_EN = 1'b0;
    @(posedge clk); #1;
    if (rw) chk("oe_off", {15'h0, LCD_DATA_OE}, 16'h0);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", {15'h0, busy}, 16'h0);
  endtask
  task automatic measure(input string nm, input int exp);
    int n = busy ? 1 : 0;
    int guard = 0;
    while (busy && guard < 400) begin
      @(posedge clk); #1;
      guard++;
      if (busy) n++;
    end
    chk(nm, 16'(n), 16'(exp));
  endtask
  task automatic cmd(input logic [7:0] d);
    push(2'd0, {8'h00, d});
    strobe(1'b0, 1'b0, d, 1);
    wait_idle();
  endtask
  task automatic chr(input logic [6:0] a, input logic [7:0] d);
    push(2'd1, {1'b0, a, d});
    strobe(1'b1, 1'b0, d, 1);
    wait_idle();
  endtask
  task automatic stat(input logic [7:0] e);
    push(2'd3, {8'h00, e});
    strobe(1'b0, 1'b1, 8'h00, 1);
  endtask
  task automatic dbg(input logic [6:0] a, input logic [7:0] e);
    dbg_rd_addr = a;
    #1;
    chk($sformatf("ddram_%0h", a), {8'h00, dbg_rd_data}, {8'h00, e});
  endtask
  task automatic all_blank(input string nm);
    int bad = 0;
    for (int i = 0; i < 128; i++) begin
      dbg_rd_addr = 7'(i);
      #1;
      if ((i[5:0] < 40) && dbg_rd_data !== 8'h20) bad++;
    end
    chk(nm, 16'(bad), 16'h0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {14'h0, state}, 16'h0);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_oe", {15'h0, LCD_DATA_OE}, 16'h0);
    chk("rst_inc", {15'h0, inc_mode}, 16'h1);
    chk("rst_disp", {13'h0, display_on, cursor_on, blink_on}, 16'h0);
    dbg(7'h00, 8'h20);
    dbg(7'h67, 8'h20);
    dbg(7'h28, 8'h00);
    rst = 1'b1;
    push(2'd0, 16'h0001);
    strobe(1'b0, 1'b0, 8'h01, 1);
    measure("clear_busy", 150);
    all_blank("clear_blank");
    stat(8'h00);
    push(2'd0, 16'h0006);
    strobe(1'b0, 1'b0, 8'h06, 1);
    measure("cmd_busy", 4);
    cmd(8'h80);
    chr(7'h00, 8'h50);
    chr(7'h01, 8'h31);
    dbg(7'h00, 8'h50);
    dbg(7'h01, 8'h31);
    stat(8'h02);
    cmd(8'hA7);
    chr(7'h27, 8'h41);
    stat(8'h40);
    dbg(7'h27, 8'h41);
    cmd(8'h04);
    chk("inc_off", {15'h0, inc_mode}, 16'h0);
    push(2'd3, 16'h0020);
    strobe(1'b1, 1'b1, 8'h00, 1);
    stat(8'h27);
    cmd(8'h14);
    stat(8'h40);
    push(2'd0, 16'h0006);
    strobe(1'b0, 1'b0, 8'h06, 1);
    push(2'd2, 16'h0000);
    strobe(1'b1, 1'b0, 8'h55, 1);
    wait_idle();
    dbg(7'h40, 8'h20);
    push(2'd0, 16'h0006);
    strobe(1'b0, 1'b0, 8'h06, 1);
    stat(8'hC0);
    wait_idle();
    push(2'd0, 16'h0006);
    strobe(1'b0, 1'b0, 8'h06, 1);
    push(2'd3, 16'h0000);
    push(2'd2, 16'h0000);
    strobe(1'b1, 1'b1, 8'h00, 1);
    wait_idle();
    stat(8'h40);
    cmd(8'h0F);
    chk("disp_flags", {13'h0, display_on, cursor_on, blink_on}, 16'h7);
    chr(7'h40, 8'h5A);
    cmd(8'hC0);
    push(2'd3, 16'h005A);
    strobe(1'b1, 1'b1, 8'h00, 2);
    stat(8'h41);
    cmd(8'h04);
    push(2'd0, 16'h0001);
    strobe(1'b0, 1'b0, 8'h01, 1);
    measure("clear2_busy", 150);
    chk("clear_inc", {15'h0, inc_mode}, 16'h1);
    all_blank("clear2_blank");
    stat(8'h00);
    push(2'd0, 16'h00B0);
    strobe(1'b0, 1'b0, 8'hB0, 1);
    measure("unmapped_busy", 4);
    stat(8'h00);
    cmd(8'hE7);
    chr(7'h67, 8'h77);
    dbg(7'h67, 8'h77);
    cmd(8'h85);
    stat(8'h05);
    push(2'd0, 16'h0001);
    strobe(1'b0, 1'b0, 8'h01, 1);
    repeat (39) @(posedge clk);
    #1;
    chk("mid_clear", {14'h0, state}, 16'h2);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst2_state", {14'h0, state}, 16'h0);
    chk("rst2_busy", {15'h0, busy}, 16'h0);
    chk("rst2_flags", {12'h0, display_on, cursor_on, blink_on, inc_mode}, 16'h1);
    chk("rst2_out", {7'h0, LCD_DATA_OE, LCD_DATA_OUT}, 16'h0);
    chk("rst2_pulses", {13'h0, cmd_valid, char_valid, err_busy}, 16'h0);
    dbg(7'h67, 8'h20);
    stat(8'h00);
    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 16'(q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
